// File: rtl/apb_master_gen.sv
// APB master: turns a valid/ready request into one APB transfer and a one-cycle response.
// Ports: pclk_m/prst_m; req_* request in; rsp_* response out; p*_m APB bus (slave k uses slice k).
module apb_master_gen #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 4,
   parameter int SLV_LSB = 12,
   parameter int TMO     = 16
) (
   input  logic                      pclk_m,
   input  logic                      prst_m,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      req_write_i,
   input  logic [ADDR_W-1:0]         req_addr_i,
   input  logic [DATA_W-1:0]         req_wdata_i,
   input  logic [DATA_W/8-1:0]       req_strb_i,
   output logic                      rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic [NUM_SLV-1:0]        psel_m,
   output logic                      penable_m,
   output logic                      pwrite_m,
   output logic [ADDR_W-1:0]         paddress_m,
   output logic [DATA_W-1:0]         pwdata_m,
   output logic [DATA_W/8-1:0]       pstrb_m,
   input  logic [NUM_SLV*DATA_W-1:0] prdata_m,
   input  logic [NUM_SLV-1:0]        pready_m,
   input  logic [NUM_SLV-1:0]        pslverr_m
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int CNT_W  = $clog2(TMO);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TMO - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic                ready_q, ready_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   strb_q, strb_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic [IDX_W-1:0]    req_idx;
   logic                req_idx_ok;
   logic                hs;
   logic [DATA_W-1:0]   sel_rdata;
   logic                sel_ready;
   logic                sel_err;

   // Ready is registered so it only rises on the first edge after reset release.
   assign hs = req_valid_i & ready_q;

   always_comb begin
      req_idx = '0;
      if (NUM_SLV > 1) req_idx = req_addr_i[SLV_LSB +: IDX_W];
   end

   assign req_idx_ok = int'(req_idx) < NUM_SLV;

   // Only the selected slave's return signals are looked at.
   always_comb begin
      sel_rdata = '0;
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (int'(idx_q) == k) begin
            sel_rdata = prdata_m[k*DATA_W +: DATA_W];
            sel_ready = pready_m[k];
            sel_err   = pslverr_m[k];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (hs) begin
               write_d = req_write_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               strb_d  = req_write_i ? req_strb_i : '0;
               idx_d   = req_idx;
               cnt_d   = '0;
               if (req_idx_ok) begin
                  state_d = SETUP;
               end else begin
                  state_d = RESP;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (sel_ready) begin
               state_d = RESP;
               rdata_d = write_q ? '0 : sel_rdata;
               err_d   = sel_err;
            end else if (cnt_q == CNT_MAX) begin
               state_d = RESP;
               rdata_d = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge pclk_m or negedge prst_m) begin
      if (!prst_m) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Bus strobes decode straight from the state flop so reset drops them at once.
   assign psel_m      = (state_q == SETUP || state_q == ACCESS)
                        ? (NUM_SLV'(1) << idx_q) : '0;
   assign penable_m   = (state_q == ACCESS);
   assign pwrite_m    = write_q;
   assign paddress_m  = addr_q;
   assign pwdata_m    = wdata_q;
   assign pstrb_m     = strb_q;
   assign req_ready_o = ready_q;
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_apb_master_gen.sv
// Directed bench for apb_master_gen: write, wait-state read, timeout,
// slave error, decode error (3-slave instance) and mid-transfer reset.
module tb_apb_master_gen;

   logic         clk;
   logic         rst_n;
   logic         req_valid, req_ready, req_write;
   logic [31:0]  req_addr, req_wdata;
   logic [3:0]   req_strb;
   logic         rsp_valid, rsp_err;
   logic [31:0]  rsp_rdata;
   logic [3:0]   psel;
   logic         penable, pwrite;
   logic [31:0]  paddr, pwdata;
   logic [3:0]   pstrb;
   logic [127:0] prdata;
   logic [3:0]   pready, pslverr;

   logic         v2, ready2, rv2, err2, pen2, pwr2;
   logic [31:0]  rdata2, paddr2, pwdata2;
   logic [2:0]   psel2;
   logic [3:0]   pstrb2;
   logic [95:0]  prdata2;
   logic [2:0]   pready2, pslverr2;

   int total = 0;
   int bad   = 0;
   int acc;

   apb_master_gen #(.NUM_SLV(4), .TMO(16)) dut (
      .pclk_m(clk), .prst_m(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_write_i(req_write), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_strb_i(req_strb),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .psel_m(psel), .penable_m(penable), .pwrite_m(pwrite),
      .paddress_m(paddr), .pwdata_m(pwdata), .pstrb_m(pstrb),
      .prdata_m(prdata), .pready_m(pready), .pslverr_m(pslverr)
   );

   apb_master_gen #(.NUM_SLV(3), .TMO(16)) dut2 (
      .pclk_m(clk), .prst_m(rst_n),
      .req_valid_i(v2), .req_ready_o(ready2),
      .req_write_i(1'b0), .req_addr_i(32'h0000_3000),
      .req_wdata_i(32'h0), .req_strb_i(4'h0),
      .rsp_valid_o(rv2), .rsp_rdata_o(rdata2), .rsp_err_o(err2),
      .psel_m(psel2), .penable_m(pen2), .pwrite_m(pwr2),
      .paddress_m(paddr2), .pwdata_m(pwdata2), .pstrb_m(pstrb2),
      .prdata_m(prdata2), .pready_m(pready2), .pslverr_m(pslverr2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic send(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_strb  = s;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
      total++; if (psel !== 4'b0 || penable !== 1'b0) begin bad++; $display("FAIL rst_psel got=%b/%b exp=0/0", psel, penable); end
      total++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pwrite !== 1'b0) begin bad++; $display("FAIL rst_bus got=%h/%h/%h/%b exp=0", paddr, pwdata, pstrb, pwrite); end
      total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp got=%b/%b/%h exp=0", rsp_valid, rsp_err, rsp_rdata); end
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
      total++; if (ready2 !== 1'b1) begin bad++; $display("FAIL rst_release_ready2 got=%b exp=1", ready2); end
   endtask

   task automatic test_write;
      pready = 4'b0010;
      pslverr = 4'b0000;
      prdata[32 +: 32] = 32'hAAAA_5555;
      send(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
      total++; if (psel !== 4'b0010 || penable !== 1'b0) begin bad++; $display("FAIL wr_setup got=%b/%b exp=0010/0", psel, penable); end
      total++; if (paddr !== 32'h1004 || pwdata !== 32'hDEADBEEF || pstrb !== 4'hF || pwrite !== 1'b1) begin bad++; $display("FAIL wr_setup_bus got=%h/%h/%h/%b exp=1004/deadbeef/f/1", paddr, pwdata, pstrb, pwrite); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL wr_setup_ready got=%b exp=0", req_ready); end
      @(posedge clk); @(negedge clk);
      total++; if (psel !== 4'b0010 || penable !== 1'b1) begin bad++; $display("FAIL wr_access got=%b/%b exp=0010/1", psel, penable); end
      @(posedge clk); @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_resp got=%b/%b/%h exp=1/0/0", rsp_valid, rsp_err, rsp_rdata); end
      total++; if (psel !== 4'b0 || penable !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL wr_resp_bus got=%b/%b/%b exp=0/0/0", psel, penable, req_ready); end
      @(posedge clk); @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL wr_idle got=%b/%b exp=0/1", rsp_valid, req_ready); end
      total++; if (paddr !== 32'h1004 || pstrb !== 4'hF || pwrite !== 1'b1) begin bad++; $display("FAIL wr_hold got=%h/%h/%b exp=1004/f/1", paddr, pstrb, pwrite); end
      pready = 4'b0000;
   endtask

   task automatic test_wait_read;
      pready = 4'b0000;
      prdata[96 +: 32] = 32'h1234_5678;
      send(1'b0, 32'h0000_3000, 32'h0, 4'hF);
      total++; if (psel !== 4'b1000 || pstrb !== 4'h0 || pwrite !== 1'b0) begin bad++; $display("FAIL rd_setup got=%b/%h/%b exp=1000/0/0", psel, pstrb, pwrite); end
      acc = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); @(negedge clk);
         if (penable !== 1'b1) break;
         acc++;
         if (acc == 4) pready[3] = 1'b1;
      end
      total++; if (acc !== 4) begin bad++; $display("FAIL rd_access_len got=%0d exp=4", acc); end
      total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0) begin bad++; $display("FAIL rd_resp got=%b/%h/%b exp=1/12345678/0", rsp_valid, rsp_rdata, rsp_err); end
      pready = 4'b0000;
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_hold got=%b/%h exp=0/12345678", rsp_valid, rsp_rdata); end
   endtask

   task automatic test_timeout;
      pready = 4'b0000;
      prdata[64 +: 32] = 32'hCAFE_F00D;
      send(1'b0, 32'h0000_2000, 32'h0, 4'h0);
      total++; if (psel !== 4'b0100) begin bad++; $display("FAIL tmo_setup got=%b exp=0100", psel); end
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); @(negedge clk);
         if (penable !== 1'b1) break;
         acc++;
      end
      total++; if (acc !== 16) begin bad++; $display("FAIL tmo_access_len got=%0d exp=16", acc); end
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL tmo_resp got=%b/%b/%h exp=1/1/0", rsp_valid, rsp_err, rsp_rdata); end
   endtask

   task automatic test_slverr;
      pready = 4'b0101;
      pslverr = 4'b0101;
      send(1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1);
      total++; if (psel !== 4'b0001) begin bad++; $display("FAIL se_setup got=%b exp=0001", psel); end
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin bad++; $display("FAIL se_err got=%b/%b exp=1/1", rsp_valid, rsp_err); end
      pready = 4'b0100;
      pslverr = 4'b0100;
      send(1'b1, 32'h0000_0020, 32'h0000_00BB, 4'h3);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      total++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL se_ignore_ready got=%b/%b exp=1/0", penable, rsp_valid); end
      pready = 4'b0101;
      @(posedge clk); @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin bad++; $display("FAIL se_ignore_err got=%b/%b exp=1/0", rsp_valid, rsp_err); end
      pready = 4'b0000;
      pslverr = 4'b0000;
   endtask

   task automatic test_decode_err;
      @(negedge clk);
      total++; if (ready2 !== 1'b1) begin bad++; $display("FAIL dec_ready got=%b exp=1", ready2); end
      v2 = 1'b1;
      @(posedge clk); @(negedge clk);
      v2 = 1'b0;
      total++; if (rv2 !== 1'b1 || err2 !== 1'b1 || rdata2 !== 32'h0) begin bad++; $display("FAIL dec_resp got=%b/%b/%h exp=1/1/0", rv2, err2, rdata2); end
      total++; if (psel2 !== 3'b000 || pen2 !== 1'b0) begin bad++; $display("FAIL dec_psel got=%b/%b exp=000/0", psel2, pen2); end
      @(negedge clk);
      total++; if (rv2 !== 1'b0 || ready2 !== 1'b1 || psel2 !== 3'b000) begin bad++; $display("FAIL dec_idle got=%b/%b/%b exp=0/1/000", rv2, ready2, psel2); end
   endtask

   task automatic test_reset_mid;
      pready = 4'b0000;
      send(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      @(posedge clk); @(negedge clk);
      total++; if (penable !== 1'b1 || psel !== 4'b0010) begin bad++; $display("FAIL rm_access got=%b/%b exp=1/0010", penable, psel); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (psel !== 4'b0 || penable !== 1'b0) begin bad++; $display("FAIL rm_async got=%b/%b exp=0/0", psel, penable); end
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || paddr !== 32'h0) begin bad++; $display("FAIL rm_in_reset got=%b/%b/%h exp=0/0/0", rsp_valid, req_ready, paddr); end
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 4'b0) begin bad++; $display("FAIL rm_release got=%b/%b/%b exp=1/0/0", req_ready, rsp_valid, psel); end
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || penable !== 1'b0) begin bad++; $display("FAIL rm_no_resp got=%b/%b exp=0/0", rsp_valid, penable); end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      req_strb = '0;
      prdata = '0;
      pready = '0;
      pslverr = '0;
      v2 = 1'b0;
      prdata2 = {3{32'h5A5A_5A5A}};
      pready2 = 3'b111;
      pslverr2 = 3'b000;
      test_reset();
      test_write();
      test_wait_read();
      test_timeout();
      test_slverr();
      test_decode_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_master_gen.md
APB_MASTER_GEN -- requirements
Module: apb_master_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width (8, 16 or 32).
REQ-003 SHALL have parameter NUM_SLV, default 4, meaning number of APB slaves (1..16).
REQ-004 SHALL have parameter SLV_LSB, default 12, meaning LSB of the slave-index field in the address.
REQ-005 SHALL have parameter TMO, default 16, meaning maximum ACCESS cycles before timeout (>=2).
REQ-006 SHALL have a clock port: pclk_m  in  1  the single clock; all state on rising edge.
REQ-007 SHALL have a reset port: prst_m  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req_valid_i  in  1  request valid.
REQ-009 SHALL have port req_ready_o  out  1  request accepted when req_valid_i and req_ready_o are both high.
REQ-010 SHALL have ports req_write_i  in  1, req_addr_i  in  ADDR_W, req_wdata_i  in  DATA_W and req_strb_i  in  DATA_W/8, the request fields.
REQ-011 SHALL have ports rsp_valid_o  out  1, rsp_rdata_o  out  DATA_W and rsp_err_o  out  1, the one-cycle response.
REQ-012 SHALL have port psel_m  out  NUM_SLV  one-hot slave select.
REQ-013 SHALL have ports penable_m  out  1, pwrite_m  out  1, paddress_m  out  ADDR_W, pwdata_m  out  DATA_W and pstrb_m  out  DATA_W/8.
REQ-014 SHALL have ports prdata_m  in  NUM_SLV*DATA_W, pready_m  in  NUM_SLV and pslverr_m  in  NUM_SLV; slave k uses slice k.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP.
REQ-016 SHALL drive req_ready_o high only in IDLE.
REQ-017 SHALL, on a handshake, register write, addr, wdata and strb, and compute idx = addr[SLV_LSB +: clog2(NUM_SLV)] (idx 0 when NUM_SLV=1).
REQ-018 SHALL go from IDLE to SETUP on a handshake when idx < NUM_SLV, otherwise to RESP with rsp_err_o=1 and rsp_rdata_o=0, with no psel_m activity (decode error).
REQ-019 SHALL, in SETUP, drive psel_m[idx]=1, penable_m=0 and stable paddress_m, pwrite_m, pwdata_m and pstrb_m, then go to ACCESS after exactly 1 cycle.
REQ-020 SHALL, in ACCESS, drive penable_m=1 while holding psel_m and all address/data/control outputs stable.
REQ-021 SHALL, in ACCESS with pready_m[idx]=1, capture prdata_m slice idx (reads; 0 for writes) and pslverr_m[idx] into rsp_err_o, then go to RESP.
REQ-022 SHALL, in ACCESS with pready_m[idx]=0, stay in ACCESS and increment the wait counter.
REQ-023 SHALL, when the wait counter reaches TMO-1 with pready_m[idx] still 0, go to RESP with rsp_err_o=1 and rsp_rdata_o=0.
REQ-024 SHALL ignore pready_m, pslverr_m and prdata_m of unselected slaves.
REQ-025 SHALL, in RESP, drive rsp_valid_o=1 for exactly 1 cycle, hold rsp_rdata_o and rsp_err_o until the next response, and return to IDLE.
REQ-026 SHALL drive psel_m=0 and penable_m=0 in IDLE and RESP.
REQ-027 SHALL take 4 cycles per zero-wait transfer from handshake to the next possible handshake, plus 1 cycle per wait state.
REQ-028 SHALL hold pwrite_m, paddress_m, pwdata_m and pstrb_m at the last transfer's values after the transfer (no return to 0).
REQ-029 SHALL drive pstrb_m=0 on reads.
REQ-030 SHALL clear the wait counter on entry to SETUP.

Reset
REQ-031 SHALL, when prst_m=0, immediately force the state to IDLE and drive req_ready_o=0, psel_m=0, penable_m=0, pwrite_m=0, paddress_m=0, pwdata_m=0, pstrb_m=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0 and wait counter=0.
REQ-032 SHALL abort any in-progress transfer on reset mid-transfer, with no rsp_valid_o generated for it.
REQ-033 SHALL raise req_ready_o on the first rising edge after prst_m deasserts.

Verification
REQ-034 SHALL be verified by: write 0x0000_1004 (idx 1), wdata 0xDEADBEEF, strb 0xF, pready_m[1]=1 -> psel_m=0010 for 2 cycles, penable_m high on the 2nd, rsp_valid_o=1 with rsp_err_o=0.
REQ-035 SHALL be verified by: read 0x0000_3000 (idx 3), pready_m[3] low for 3 ACCESS cycles, prdata slice 3=0x12345678 -> ACCESS lasts 4 cycles, rsp_rdata_o=0x12345678, rsp_err_o=0.
REQ-036 SHALL be verified by: read with pready never asserted, TMO=16 -> exactly 16 ACCESS cycles, then rsp_valid_o=1 with rsp_err_o=1 and rsp_rdata_o=0.
REQ-037 SHALL be verified by: NUM_SLV=3, addr 0x0000_3000 -> no psel_m pulse, rsp_valid_o 1 cycle after the handshake with rsp_err_o=1.
REQ-038 SHALL be verified by: pslverr_m[0]=1 at pready on a write to idx 0 -> rsp_err_o=1; a concurrent pslverr_m[2]=1 is ignored.
REQ-039 SHALL be verified by: prst_m low during ACCESS -> psel_m and penable_m fall asynchronously, no response, and req_ready_o=1 after release.
